// File: rtl/ascii_pkg.sv
// Shared ASCII case-conversion constants and helpers for the toLower/toUpper
// stream datapaths.
package ascii_pkg;

  localparam logic [7:0] ASCII_UPPER_A     = 8'd65;
  localparam logic [7:0] ASCII_UPPER_Z     = 8'd90;
  localparam logic [7:0] ASCII_LOWER_A     = 8'd97;
  localparam logic [7:0] ASCII_LOWER_Z     = 8'd122;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'd32;

  localparam int ENTRY_W = 9;

  // One FIFO slot: the already-converted byte plus whether conversion changed it.
  typedef struct packed {
    logic       changed;
    logic [7:0] data;
  } entry_t;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z);
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] b);
    return is_upper(b) ? (b + ASCII_CASE_OFFSET) : b;
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return is_lower(b) ? (b - ASCII_CASE_OFFSET) : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy count; pointers wrap naturally
// (DEPTH must be a power of two).
module sync_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is data-only: never reset, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ascii_to_lower_stream.sv
// Streaming ASCII to-lowercase converter: valid/ready in, FIFO, valid/ready out,
// with saturating delivered/converted byte counters.
module ascii_to_lower_stream
  import ascii_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [LVL_W-1:0] level,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] char_count,
  output logic [CNT_W-1:0] conv_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc);
    return (&c) ? c : (c + CNT_W'(inc));
  endfunction

  entry_t           wr_entry, rd_entry;
  logic             push, pop, full, empty;
  logic [CNT_W-1:0] char_q, char_d;
  logic [CNT_W-1:0] conv_q, conv_d;

  // in_ready depends only on occupancy, never on out_ready.
  assign in_ready  = rst_n & ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_entry = {is_upper(in_data), to_lower(in_data)};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .rd_data (rd_entry)
  );

  // Storage is not reset, so the output is forced to zero whenever nothing is held.
  assign out_data = out_valid ? rd_entry.data : 8'h00;

  always_comb begin
    char_d = char_q;
    conv_d = conv_q;
    if (clr_counts) begin
      char_d = '0;
      conv_d = '0;
    end else if (pop) begin
      char_d = sat_inc(char_q, 1'b1);
      conv_d = sat_inc(conv_q, rd_entry.changed);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_q <= '0;
      conv_q <= '0;
    end else begin
      char_q <= char_d;
      conv_q <= conv_d;
    end
  end

  assign char_count = char_q;
  assign conv_count = conv_q;

endmodule

// File: tb/tb_ascii_to_lower_stream.sv
// Directed + randomized bench for ascii_to_lower_stream against a queue-based
// reference of the byte stream and its counters.
module tb_ascii_to_lower_stream;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic [LVL_W-1:0] level;
  logic             clr_counts = 1'b0;
  logic [CNT_W-1:0] char_count;
  logic [CNT_W-1:0] conv_count;

  ascii_to_lower_stream #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .clr_counts (clr_counts),
    .char_count (char_count),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: raw bytes in arrival order, plus delivered/changed totals.
  logic [7:0] mq[$];
  int         m_char = 0;
  int         m_conv = 0;

  function automatic logic is_cap(input logic [7:0] b);
    return (b >= 8'd65) && (b <= 8'd90);
  endfunction

  function automatic logic [7:0] ref_lower(input logic [7:0] b);
    return is_cap(b) ? b + 8'd32 : b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check in_ready, advance the model, check state after the edge.
  task automatic step(input logic rn, input logic v, input logic [7:0] d,
                      input logic r, input logic clr, output logic acc);
    logic       exp_rdy, do_pop;
    logic [7:0] b;
    rst_n      = rn;
    in_valid   = v;
    in_data    = v ? d : 8'hxx;
    out_ready  = r;
    clr_counts = clr;
    #1;
    exp_rdy = rn && (mq.size() < DEPTH);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc    = v && exp_rdy;
    do_pop = (mq.size() != 0) && r;
    if (!rn) begin
      mq.delete();
      m_char = 0;
      m_conv = 0;
    end else begin
      if (do_pop) begin
        b = mq.pop_front();
        if (m_char < CNT_MAX) m_char++;
        if (is_cap(b) && m_conv < CNT_MAX) m_conv++;
      end
      if (acc) mq.push_back(d);
      if (clr) begin
        m_char = 0;
        m_conv = 0;
      end
    end
    @(posedge clk);
    #1;
    check("level", 32'(level), 32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("out_data", 32'(out_data), 32'((mq.size() != 0) ? ref_lower(mq[0]) : 8'h00));
    check("char_count", 32'(char_count), 32'(m_char));
    check("conv_count", 32'(conv_count), 32'(m_conv));
  endtask

  initial begin
    logic       acc;
    logic [7:0] t2 [7];
    logic [7:0] t3 [5];
    t2 = '{8'd65, 8'd90, 8'd97, 8'd64, 8'd91, 8'd200, 8'd127};
    t3 = '{8'h48, 8'h65, 8'h4C, 8'h50, 8'h21};

    // Reset held for three cycles, then released.
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_char", 32'(char_count), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Conversion stream with sink always ready.
    foreach (t2[i]) step(1'b1, 1'b1, t2[i], 1'b1, 1'b0, acc);
    repeat (2) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("t2_char_final", 32'(char_count), 32'd7);
    check("t2_conv_final", 32'(conv_count), 32'd2);

    // Backpressure: fifth byte waits until a slot frees up.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, t3[i], 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, t3[4], 1'b0, 1'b0, acc);
    check("t3_full_level", 32'(level), 32'd4);
    check("t3_full_in_ready", 32'(in_ready), 32'd0);
    check("t3_stable_data", 32'(out_data), 32'h68);
    step(1'b1, 1'b1, t3[4], 1'b1, 1'b0, acc);
    check("t4_full_pushpop_level", 32'(level), 32'd3);
    step(1'b1, 1'b1, t3[4], 1'b1, 1'b0, acc);
    repeat (5) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Simultaneous push and pop at level 2.
    step(1'b1, 1'b1, 8'h51, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 8'h72, 1'b0, 1'b0, acc);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h53 + 8'(i), 1'b1, 1'b0, acc);
    check("t4_pushpop_level", 32'(level), 32'd2);
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Reset mid-stream at level 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, acc);
    check("t5_rst_level", 32'(level), 32'd0);
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, acc);
    check("t5_first_after_rst", 32'(out_data), 32'h7A);
    step(1'b1, 1'b1, 8'h30, 1'b1, 1'b0, acc);
    repeat (2) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Counter saturation, then clear racing a pop.
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'h41 + 8'(i % 26), 1'b1, 1'b0, acc);
    repeat (2) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("t6_char_sat", 32'(char_count), 32'd15);
    check("t6_conv_sat", 32'(conv_count), 32'd15);
    step(1'b1, 1'b1, 8'h4B, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    check("t6_clr_char", 32'(char_count), 32'd0);
    check("t6_clr_conv", 32'(conv_count), 32'd0);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      logic       rn, v, r, clr;
      logic [7:0] d;
      rn  = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      d   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(65, 90)) : 8'($urandom_range(0, 255));
      step(rn, v, d, r, clr, acc);
    end
    repeat (6) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
